// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one memory request in flight
// at a time, and presents responses through an output register backed by a skid entry.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_ctrl,
  input  logic [31:0] br_dst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] current_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_KILL  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic [31:0] out_inst_reg, out_inst_next;
  logic        skid_full_reg, skid_full_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic [31:0] skid_inst_reg, skid_inst_next;

  logic consume;
  logic req;
  logic accept;

  // A held output blocks new requests so a response always has somewhere to land.
  assign consume = out_valid_reg && !stall;
  assign req     = (state_reg == S_ISSUE) && !skid_full_reg && !(out_valid_reg && stall);
  assign accept  = req && imem_ready;

  assign imem_req   = req;
  assign imem_addr  = pc_reg;
  assign current_pc = pc_reg;
  assign if_valid   = out_valid_reg;
  assign if_pc      = out_pc_reg;
  assign if_inst    = out_inst_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_BOOT;
      pc_reg        <= RESET_PC;
      req_pc_reg    <= RESET_PC;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= 32'h0000_0000;
      out_inst_reg  <= NOP_INST;
      skid_full_reg <= 1'b0;
      skid_pc_reg   <= 32'h0000_0000;
      skid_inst_reg <= NOP_INST;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_pc_reg    <= req_pc_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_inst_reg  <= out_inst_next;
      skid_full_reg <= skid_full_next;
      skid_pc_reg   <= skid_pc_next;
      skid_inst_reg <= skid_inst_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_pc_next    = req_pc_reg;
    out_valid_next = out_valid_reg;
    out_pc_next    = out_pc_reg;
    out_inst_next  = out_inst_reg;
    skid_full_next = skid_full_reg;
    skid_pc_next   = skid_pc_reg;
    skid_inst_next = skid_inst_reg;

    case (state_reg)
      S_BOOT: state_next = S_ISSUE;
      S_ISSUE: begin
        if (accept) begin
          req_pc_next = pc_reg;
          state_next  = br_ctrl ? S_KILL : S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect racing the response simply drops it; otherwise the stale one must be eaten later.
        if (br_ctrl) begin
          state_next = imem_rvalid ? S_ISSUE : S_KILL;
        end else if (imem_rvalid) begin
          state_next = S_ISSUE;
          pc_next    = req_pc_reg + 32'd4;
        end
      end
      S_KILL: begin
        if (imem_rvalid) state_next = S_ISSUE;
      end
      default: state_next = S_BOOT;
    endcase

    if (state_reg != S_BOOT) begin
      if (br_ctrl) begin
        pc_next        = br_dst;
        out_valid_next = 1'b0;
        out_inst_next  = NOP_INST;
        skid_full_next = 1'b0;
      end else begin
        if (consume) begin
          if (skid_full_reg) begin
            out_pc_next    = skid_pc_reg;
            out_inst_next  = skid_inst_reg;
            skid_full_next = 1'b0;
          end else begin
            out_valid_next = 1'b0;
          end
        end
        // Land in the output only when that cannot overtake an older skid entry.
        if (state_reg == S_WAIT && imem_rvalid) begin
          if (!out_valid_reg || (consume && !skid_full_reg)) begin
            out_valid_next = 1'b1;
            out_pc_next    = req_pc_reg;
            out_inst_next  = imem_rdata;
          end else begin
            skid_full_next = 1'b1;
            skid_pc_next   = req_pc_reg;
            skid_inst_next = imem_rdata;
          end
        end
      end
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the pipeline control signals and the instruction memory port. It owns the architectural fetch PC, issues one request at a time over a req/ready address handshake, and accepts the response on a valid strobe. Fetched instructions are presented to the IF/ID stage through an output register backed by a one-entry skid buffer. Branch redirects and stalls are resolved here, including discarding responses that are already in flight.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded at reset
- NOP_INST, 32'h0000_0013, value driven on if_inst at reset and on flush
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-low; sampled on posedge clk, asserted when 0
- stall  in  1  IF/ID hold; when 1 the output register is not consumed
- br_ctrl  in  1  redirect request; fetch resumes at br_dst
- br_dst  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request address, always equal to current_pc
- imem_ready  in  1  memory accepts the request when imem_req && imem_ready
- imem_rvalid  in  1  response valid (one per accepted request; at least 1 cycle after accept)
- imem_rdata  in  32  response instruction
- current_pc  out  32  next address to fetch
- if_valid  out  1  if_inst/if_pc hold a live instruction
- if_pc  out  32  PC of if_inst
- if_inst  out  32  fetched instruction

## Operation
- Priority: reset > br_ctrl > response/handshake.
- Consumption: the output register is consumed when if_valid && !stall. If the skid entry is full, it moves into the output register in the same cycle.
- At most one request is outstanding. req_pc latches current_pc on acceptance.
- State BOOT (entered on reset): imem_req=0. Goes to ISSUE on the next cycle.
- State ISSUE: imem_req = !skid_full && !(if_valid && stall).
  - On acceptance: go to WAIT.
  - On br_ctrl with acceptance in the same cycle: go to KILL.
- State WAIT: on imem_rvalid, the instruction {req_pc, rdata} goes to the output register if that register is empty or being consumed; otherwise it goes to skid. Then current_pc <= req_pc+4 and the state goes to ISSUE.
- State KILL: the next imem_rvalid is discarded, then the state goes to ISSUE.
- br_ctrl handling, in any state after BOOT:
  - current_pc <= br_dst.
  - Output and skid are flushed: if_valid=0, if_inst=NOP_INST, skid emptied.
  - The next state depends on the current state:
    - WAIT without rvalid: go to KILL.
    - WAIT with rvalid in the same cycle: the response is dropped and the state goes to ISSUE.
    - KILL: stay in KILL.
    - ISSUE without acceptance: stay in ISSUE. The request address may change because memory samples it only on acceptance.
- imem_rvalid in BOOT or ISSUE is a protocol error and is ignored.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. br_dst is used unaligned as given.
- Skid full implies if_valid=1. The two entries are never reordered.

## Timing
- Reset values:
  - state=BOOT
  - current_pc=imem_addr=RESET_PC
  - imem_req=0
  - if_valid=0, if_pc=0, if_inst=NOP_INST
  - skid empty
- Reset asserted mid-transaction aborts everything. Any response to the aborted request is the memory's responsibility to suppress.
- Best case, with imem_ready=1 and rvalid 1 cycle after accept:
  - Accept at cycle n, rvalid at n+1, if_valid visible at n+2.
  - Next request is issued at n+2.
  - Steady throughput is 1 instruction per 2 cycles.
- First request after reset release: reset high at edge k, imem_req=1 from cycle k+1.
- Redirect takes effect one edge later: current_pc=br_dst and if_valid=0 in the cycle after br_ctrl is sampled.
- A stalled output holds if_valid, if_pc and if_inst stable for as long as stall=1, unless br_ctrl flushes it.

## Test plan
- Reset release with RESET_PC=0, imem_ready=1, 1-cycle memory:
  - Requests go to 0, 4, 8.
  - if_pc sequence 0, 4, 8 with matching if_inst.
  - if_valid first rises 3 cycles after reset release.
- Stall held for 5 cycles with a response in flight: the response lands in skid, and no new request is issued while skid is full. After stall releases, the bench sees if_pc 0x8 then 0xC in consecutive cycles, with no loss or duplication.
- br_ctrl=1, br_dst=0x100 while in WAIT: the in-flight response (rdata=0xDEADBEEF) is never presented. The next request goes to 0x100 and the first valid if_pc is 0x100.
- br_ctrl coincident with imem_rvalid in WAIT: the response is dropped, and imem_req to br_dst is asserted in the next cycle.
- imem_ready=0 for 4 cycles in ISSUE with br_ctrl to 0x40 in cycle 2: imem_addr changes to 0x40 and the accepted address is 0x40. Separately, current_pc at 0xFFFF_FFFC wraps to 0x0.
- reset driven low while in KILL: all outputs return to their reset values on the next edge.
